iq_demod: RTL
=============

// Module: iq_demod
// PURPOSE
// Receive-path counterpart of the transmit modulator/sampler chain: mixes 8-bit ADC samples with the
// phase_accum LO (cos/sin), integrates-and-dumps over 2**LOG2_DECIM samples, and writes I then Q
// bytes into the shared 8-bit FIFO for SPI readback by the controller. Sits between ADC capture and fifo.
// PARAMETERS
// LOG2_DECIM   4   decimation = 2**LOG2_DECIM input samples per I/Q pair; legal range 1..8
// PORTS
// clk              in   1   system clock (PLL output)
// rst              in   1   synchronous, active-high reset
// en               in   1   demod enable; low clears datapath, suppresses writes
// adc_data         in   8   ADC sample, offset binary (0x80 = zero)
// adc_valid        in   1   adc_data/phase qualifier, one sample per high cycle
// phase            in   8   LO phase from phase_accum, sampled with adc_valid
// fifo_space_free  in  13   free bytes in FIFO
// fifo_wr          out  1   FIFO write strobe
// fifo_data_in     out  8   FIFO write data, two's complement I or Q
// ovf_clr          in   1   clears overflow and drop_count
// overflow         out  1   sticky: at least one I/Q pair dropped
// drop_count       out  8   dropped pairs, saturates at 255
// BEHAVIOUR
// - Reset: fifo_wr=0, fifo_data_in=0, overflow=0, drop_count=0, accumulators/counter=0, state IDLE.
// - Sample conversion: s = {~adc_data[7], adc_data[6:0]} signed (-128..127).
// - LO table: 256 entries, cos[p]=round(127*cos(2*pi*p/256)), sin[p]=round(127*sin(2*pi*p/256)), signed 8b.
// - Pipeline, valid at T0: T0+1 reg s,cos,sin; T0+2 reg pi=s*cos, pq=s*sin (signed 16b);
//   T0+3 acc_i/acc_q (signed 16+LOG2_DECIM b) += products, sample count increments.
// - Dump: on the stage-2 valid that completes count==2**LOG2_DECIM-1: total = acc+product;
//   hold_i/hold_q <= total >>> (7+LOG2_DECIM), low 8 bits (always in -128..127, no saturation);
//   acc<=0, count<=0 same cycle; accumulation of next block continues uninterrupted.
// - Write FSM IDLE->WR_I->WR_Q->IDLE: on dump, if fifo_space_free>=2 go WR_I, else drop pair.
//   WR_I: fifo_wr=1, fifo_data_in=hold_i. WR_Q: fifo_wr=1, fifo_data_in=hold_q. Pairs never split.
//   I byte appears on FIFO write port 4 cycles after the final adc_valid of the block, Q at 5.
// - Drop: overflow<=1, drop_count<=min(drop_count+1,255). Dump and ovf_clr same cycle: clear wins,
//   then drop counted next (result overflow=1, drop_count=1).
// - adc_valid gaps: pipeline holds, only valid samples counted; back-to-back valid legal (LOG2_DECIM>=1
//   guarantees dumps >=2 cycles apart, FSM never busy at a dump).
// - en low: pipeline valids, acc, count cleared each cycle; pair already in WR_I/WR_Q completes.
//   en high resumes with a fresh block; partial block at en drop discarded, not counted as drop.
// - rst mid-write: FSM to IDLE immediately, fifo_wr=0 next cycle, pending Q byte lost.
// CONFIGURATION
// IQ_DEMOD_ROUND_EN defined: add 2**(6+LOG2_DECIM) to total before shift (round half up).
// IQ_DEMOD_ROUND_EN undefined: plain arithmetic shift (floor). Result range -128..127 either way.
// TESTING
// 1 Reset: assert rst 2 cycles -> fifo_wr=0, fifo_data_in=0x00, overflow=0, drop_count=0.
// 2 DC, LOG2_DECIM=4: adc_data=0xFF, phase=0, 16 valids -> writes 0x7E (I=126) then 0x00 (Q=0).
// 3 Quadrature: adc_data=0xFF, phase=64, 16 valids -> I=0x00, Q=0x7E; adc_data=0x00, phase=0 -> I=0x81.
// 4 Full: fifo_space_free=1 at dump -> no fifo_wr, overflow=1, drop_count=1; ovf_clr -> both 0.
// 5 en dropped after 8 valids then raised, 16 valids -> exactly one pair, value as test 2.
// 6 Rounding: adc_data=0x81, phase=0, 16 valids -> I=0x00 without IQ_DEMOD_ROUND_EN, 0x01 with it.

Source files
------------

// File: rtl/iq_demod.sv
// I/Q demodulator: mixes ADC samples with the LO, integrates and dumps over 2**LOG2_DECIM samples,
// and writes I then Q bytes to the FIFO. Define IQ_DEMOD_ROUND_EN for round-half-up on the dump.
module iq_demod #(
  parameter int LOG2_DECIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  adc_data,
  input  logic        adc_valid,
  input  logic [7:0]  phase,
  input  logic [12:0] fifo_space_free,
  output logic        fifo_wr,
  output logic [7:0]  fifo_data_in,
  input  logic        ovf_clr,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int ACC_W = 16 + LOG2_DECIM;
  localparam int SHIFT = 7 + LOG2_DECIM;
  localparam logic [LOG2_DECIM-1:0] LAST = '1;
`ifdef IQ_DEMOD_ROUND_EN
  localparam int RND = 1 << (6 + LOG2_DECIM);
`else
  localparam int RND = 0;
`endif

  // First quadrant of round(127*sin(2*pi*k/256)), k = 0..64
  localparam int QSIN [0:64] = '{
      0,   3,   6,   9,  12,  16,  19,  22,  25,  28,  31,  34,  37,  40,  43,  46,
     49,  51,  54,  57,  60,  63,  65,  68,  71,  73,  76,  78,  81,  83,  85,  88,
     90,  92,  94,  96,  98, 100, 102, 104, 106, 107, 109, 111, 112, 113, 115, 116,
    117, 118, 120, 121, 122, 122, 123, 124, 125, 125, 126, 126, 126, 127, 127, 127,
    127};

  typedef enum logic [1:0] {IDLE, WR_I, WR_Q} state_t;

  function automatic logic signed [7:0] lo_sin(input logic [7:0] p);
    logic [6:0] k;
    logic [6:0] mag;
    k   = p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
    mag = 7'(QSIN[k]);
    lo_sin = p[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  logic                    v1, v2, dump_q;
  logic signed [7:0]       s1, c1, n1;
  logic signed [15:0]      p_i, p_q;
  logic signed [ACC_W-1:0] acc_i, acc_q;
  logic [LOG2_DECIM-1:0]   count;
  logic [7:0]              hold_i, hold_q;
  logic signed [ACC_W:0]   tot_i, tot_q;
  state_t                  state;
  logic                    drop_now, drop_pend;

  always_comb begin
    tot_i = (ACC_W+1)'(acc_i) + (ACC_W+1)'(p_i) + (ACC_W+1)'(RND);
    tot_q = (ACC_W+1)'(acc_q) + (ACC_W+1)'(p_q) + (ACC_W+1)'(RND);
  end

  // Mixer pipeline and integrate-and-dump; en low flushes everything not yet dumped
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;   v2 <= 1'b0;   dump_q <= 1'b0;
      s1 <= '0;     c1 <= '0;     n1 <= '0;
      p_i <= '0;    p_q <= '0;
      acc_i <= '0;  acc_q <= '0;  count <= '0;
      hold_i <= '0; hold_q <= '0;
    end else begin
      dump_q <= 1'b0;
      v1 <= en & adc_valid;
      v2 <= en & v1;
      if (adc_valid) begin
        s1 <= {~adc_data[7], adc_data[6:0]};
        c1 <= lo_sin(phase + 8'd64);
        n1 <= lo_sin(phase);
      end
      if (v1) begin
        p_i <= 16'(s1) * 16'(c1);
        p_q <= 16'(s1) * 16'(n1);
      end
      if (!en) begin
        acc_i <= '0;
        acc_q <= '0;
        count <= '0;
      end else if (v2) begin
        if (count == LAST) begin
          hold_i <= 8'(tot_i >>> SHIFT);
          hold_q <= 8'(tot_q >>> SHIFT);
          acc_i  <= '0;
          acc_q  <= '0;
          count  <= '0;
          dump_q <= 1'b1;
        end else begin
          acc_i <= acc_i + ACC_W'(p_i);
          acc_q <= acc_q + ACC_W'(p_q);
          count <= count + 1'b1;
        end
      end
    end
  end

  assign drop_now = dump_q && (state != WR_I) && (fifo_space_free < 13'd2);

  // WR_Q accepts a new dump just like IDLE, so back-to-back dumps are never missed
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      fifo_wr      <= 1'b0;
      fifo_data_in <= '0;
      overflow     <= 1'b0;
      drop_count   <= '0;
      drop_pend    <= 1'b0;
    end else begin
      case (state)
        WR_I: begin
          state        <= WR_Q;
          fifo_wr      <= 1'b1;
          fifo_data_in <= hold_q;
        end
        default: begin
          if (dump_q && fifo_space_free >= 13'd2) begin
            state        <= WR_I;
            fifo_wr      <= 1'b1;
            fifo_data_in <= hold_i;
          end else begin
            state   <= IDLE;
            fifo_wr <= 1'b0;
          end
        end
      endcase

      // A clear coinciding with a drop wins; the drop is then counted one cycle later
      if (ovf_clr) begin
        overflow   <= 1'b0;
        drop_count <= '0;
        drop_pend  <= drop_pend | drop_now;
      end else if (drop_now || drop_pend) begin
        overflow   <= 1'b1;
        drop_count <= (drop_count == 8'hFF) ? drop_count : drop_count + 8'd1;
        drop_pend  <= 1'b0;
      end
    end
  end

endmodule
